// File: rtl/serial_rx_param_pkg.sv
// Shared constants and FSM state encoding for the parametrised serial receiver.
package serial_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

endpackage

// File: rtl/serial_rx_param_bit_timer.sv
// Bit-period timer: strobes at the mid-bit offset h after restart, then once per bit period.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart_i,
    output logic sample_o
);

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // Restart is held through the detection cycle, so the next cycle is offset 1.
    localparam logic [CW-1:0] LOAD = (CLKS_PER_BIT > 1) ? CW'(1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart_i)          cnt_d = LOAD;
        else if (cnt_q == LAST) cnt_d = '0;
        else                    cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign sample_o = (cnt_q == CW'(H));

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised async-serial frame receiver: start, DATA_WIDTH bits, optional parity, stop.
// Define SERIAL_RX_SYNC_EN to add a two-flop input synchroniser (+2 cycles latency).
module serial_rx_param
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 7,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_MODE  = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  parity_ok_n,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int H       = (CLKS_PER_BIT - 1) / 2;
    localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);

    state_e                  state_q;
    logic [BW-1:0]           bit_q;
    logic [DATA_WIDTH-1:0]   shreg_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_q, ready_q, pok_n_q, ferr_q;
    logic                    rx, tick, par_err_d;

`ifdef SERIAL_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], serial_in};
    end
    assign rx = sync_q[1];
`else
    assign rx = serial_in;
`endif

    serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .restart_i (state_q == IDLE),
        .sample_o  (tick)
    );

    always_comb begin
        shift_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
        if (MSB_FIRST != 0) shift_d[0]            = rx;
        else                shift_d[DATA_WIDTH-1] = rx;
    end

    always_comb begin
        par_err_d = 1'b0;
        if (PARITY_MODE == PARITY_EVEN)     par_err_d = ^{shreg_q, par_q};
        else if (PARITY_MODE == PARITY_ODD) par_err_d = ~^{shreg_q, par_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
            pok_n_q <= 1'b1;
            ferr_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_q <= '0;
                    // With h=0 the detection cycle doubles as the start-bit sample.
                    if (!rx) state_q <= (H == 0) ? DATA : START;
                end
                START: if (tick) state_q <= rx ? IDLE : DATA;
                DATA: if (tick) begin
                    shreg_q <= shift_d;
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == BW'(DATA_WIDTH - 1)) state_q <= HAS_PAR ? PARITY : STOP;
                end
                PARITY: if (tick) begin
                    par_q   <= rx;
                    state_q <= STOP;
                end
                STOP: if (tick) begin
                    data_q  <= shreg_q;
                    ready_q <= 1'b1;
                    pok_n_q <= par_err_d;
                    ferr_q  <= ~rx;
                    state_q <= rx ? IDLE : BREAK;
                end
                BREAK: if (rx) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign ready       = ready_q;
    assign parity_ok_n = pok_n_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param: three configurations on a shared clock/reset.
module tb_serial_rx_param;

`ifdef SERIAL_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0, rstn = 1'b0;
    logic si0 = 1'b1, si1 = 1'b1, si2 = 1'b1;
    logic [6:0] d0, d1;
    logic [7:0] d2;
    logic r0, r1, r2, p0, p1, p2, f0, f1, f2, b0, b1, b2;

    int cyc = 0, total = 0, bad = 0, t0 = 0;
    int rc0 = 0, rc1 = 0, rc2 = 0, ry0 = 0, ry2 = 0;
    int n0, n1, n2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ready seen at the negedge after posedge k is the pulse of cycle k+1.
    always @(negedge clk) begin
        if (r0) begin rc0 = rc0 + 1; ry0 = cyc + 1; end
        if (r1) rc1 = rc1 + 1;
        if (r2) begin rc2 = rc2 + 1; ry2 = cyc + 1; end
    end

    serial_rx_param u0 (
        .clk(clk), .rstn(rstn), .serial_in(si0), .data_out(d0), .ready(r0),
        .parity_ok_n(p0), .frame_err(f0), .busy(b0));

    serial_rx_param #(.CLKS_PER_BIT(8)) u1 (
        .clk(clk), .rstn(rstn), .serial_in(si1), .data_out(d1), .ready(r1),
        .parity_ok_n(p1), .frame_err(f1), .busy(b1));

    serial_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .MSB_FIRST(0)) u2 (
        .clk(clk), .rstn(rstn), .serial_in(si2), .data_out(d2), .ready(r2),
        .parity_ok_n(p2), .frame_err(f2), .busy(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v);
        case (d)
            0:       si0 = v;
            1:       si1 = v;
            default: si2 = v;
        endcase
    endtask

    // Sends seq[n-1] first, each bit held c cycles; call at a negedge. Line left at last bit.
    task automatic send(input int d, input int c, input logic [31:0] seq, input int n);
        t0 = cyc + 1;
        for (int i = n - 1; i >= 0; i--) begin
            drive(d, seq[i]);
            repeat (c) @(negedge clk);
        end
    endtask

    task automatic wait_cyc(input int c);
        for (int k = 0; k < 200 && cyc < c; k++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(d0), 32'h0);
        chk("rst_ready", 32'(r0), 32'h0);
        chk("rst_pok_n", 32'(p0), 32'h1);
        chk("rst_ferr", 32'(f0), 32'h0);
        chk("rst_busy", 32'(b0), 32'h0);
        chk("rst_busy2", 32'(b2), 32'h0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Good even-parity frame, MSB first
        n0 = rc0;
        send(0, 1, 32'b0_1010011_0_1, 10);
        drive(0, 1'b1);
        repeat (5 + LAT) @(negedge clk);
        chk("f1_cnt", 32'(rc0), 32'(n0 + 1));
        chk("f1_time", 32'(ry0), 32'(t0 + 10 + LAT));
        chk("f1_data", 32'(d0), 32'h53);
        chk("f1_pok_n", 32'(p0), 32'h0);
        chk("f1_ferr", 32'(f0), 32'h0);
        chk("f1_busy", 32'(b0), 32'h0);

        // Parity bit wrong
        n0 = rc0;
        send(0, 1, 32'b0_1010011_1_1, 10);
        drive(0, 1'b1);
        repeat (5 + LAT) @(negedge clk);
        chk("f2_cnt", 32'(rc0), 32'(n0 + 1));
        chk("f2_time", 32'(ry0), 32'(t0 + 10 + LAT));
        chk("f2_data", 32'(d0), 32'h53);
        chk("f2_pok_n", 32'(p0), 32'h1);

        // Stop bit low, then line held low: one delivery, no retrigger
        n0 = rc0;
        send(0, 1, 32'b0_1010011_0_0, 10);
        repeat (20) @(negedge clk);
        chk("brk_cnt", 32'(rc0), 32'(n0 + 1));
        chk("brk_ferr", 32'(f0), 32'h1);
        chk("brk_data", 32'(d0), 32'h53);
        chk("brk_busy", 32'(b0), 32'h1);
        drive(0, 1'b1);
        repeat (3 + LAT) @(negedge clk);
        chk("brk_idle", 32'(b0), 32'h0);
        send(0, 1, 32'b0_0101010_1_1, 10);
        drive(0, 1'b1);
        repeat (5 + LAT) @(negedge clk);
        chk("rec_cnt", 32'(rc0), 32'(n0 + 2));
        chk("rec_data", 32'(d0), 32'h2A);
        chk("rec_ferr", 32'(f0), 32'h0);
        chk("rec_pok_n", 32'(p0), 32'h0);

        // False start on the C=8 receiver
        n1 = rc1;
        drive(1, 1'b0);
        t0 = cyc + 1;
        repeat (2) @(negedge clk);
        drive(1, 1'b1);
        wait_cyc(t0 + 2 + LAT);
        chk("fs_busy_hi", 32'(b1), 32'h1);
        wait_cyc(t0 + 3 + LAT);
        chk("fs_busy_lo", 32'(b1), 32'h0);
        repeat (20) @(negedge clk);
        chk("fs_noready", 32'(rc1), 32'(n1));
        chk("fs_data", 32'(d1), 32'h0);

        // W=8, C=4, odd parity, LSB first
        n2 = rc2;
        send(2, 4, 32'b0_10100101_1_1, 11);
        drive(2, 1'b1);
        repeat (8 + LAT) @(negedge clk);
        chk("w8_cnt", 32'(rc2), 32'(n2 + 1));
        chk("w8_time", 32'(ry2), 32'(t0 + 42 + LAT));
        chk("w8_data", 32'(d2), 32'hA5);
        chk("w8_pok_n", 32'(p2), 32'h0);
        chk("w8_ferr", 32'(f2), 32'h0);
        send(2, 4, 32'b0_01100000_0_1, 11);
        drive(2, 1'b1);
        repeat (8 + LAT) @(negedge clk);
        chk("w8b_data", 32'(d2), 32'h06);
        chk("w8b_pok_n", 32'(p2), 32'h1);

        // Reset during data bit 3 aborts the frame
        n0 = rc0;
        send(0, 1, 32'b0_1010, 5);
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_data", 32'(d0), 32'h0);
        chk("mr_ready", 32'(r0), 32'h0);
        chk("mr_pok_n", 32'(p0), 32'h1);
        chk("mr_ferr", 32'(f0), 32'h0);
        chk("mr_busy", 32'(b0), 32'h0);
        drive(0, 1'b1);
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        chk("mr_noready", 32'(rc0), 32'(n0));
        send(0, 1, 32'b0_1010011_0_1, 10);
        drive(0, 1'b1);
        repeat (5 + LAT) @(negedge clk);
        chk("mr2_cnt", 32'(rc0), 32'(n0 + 1));
        chk("mr2_time", 32'(ry0), 32'(t0 + 10 + LAT));
        chk("mr2_data", 32'(d0), 32'h53);
        chk("mr2_pok_n", 32'(p0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
